// File: rtl/mul_hilo_ctrl.sv
// rtl/mul_hilo_ctrl.sv - EXE-stage multiply/HI-LO controller for a 2-stage pipelined multiplier
module mul_hilo_ctrl #(
  parameter int MUL_LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_op,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  input  logic        flush,
  output logic [32:0] mul_a,
  output logic [32:0] mul_b,
  input  logic [65:0] mul_p,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] hilo_wdata,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int CW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

  typedef enum logic [2:0] {S_IDLE, S_MUL, S_CAP, S_ACC, S_DONE} state_t;

  state_t         state_q, state_d;
  logic [2:0]     op_q, op_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [32:0]    mul_a_q, mul_a_d, mul_b_q, mul_b_d;
  logic [63:0]    prod_q, prod_d;
  logic [31:0]    hi_q, hi_d, lo_q, lo_d, res_q, res_d;
  logic [63:0]    hilo_new;
  logic           hilo_wr;
  logic           accept;
  logic           in_signed, op_acc, op_sub;
  logic [1:0]     unused_p;

  assign unused_p  = mul_p[65:64];
  assign accept    = in_valid && in_ready && !flush;
  assign in_signed = (in_op == 3'd0) || (in_op == 3'd2) || (in_op == 3'd3) || (in_op == 3'd5);
  assign op_acc    = (op_q >= 3'd3) && (op_q <= 3'd6);
  assign op_sub    = (op_q == 3'd5) || (op_q == 3'd6);

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  if (accept) state_d = S_MUL;
        S_MUL:   if (cnt_q == '0) state_d = S_CAP;
        S_CAP:   state_d = op_acc ? S_ACC : S_DONE;
        S_ACC:   state_d = S_DONE;
        S_DONE:  if (out_ready) state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    in_ready  = (state_q == S_IDLE) && !rst;
    out_valid = (state_q == S_DONE);
  end

  always_comb begin
    op_d     = op_q;
    cnt_d    = cnt_q;
    mul_a_d  = mul_a_q;
    mul_b_d  = mul_b_q;
    prod_d   = prod_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    res_d    = res_q;
    hilo_new = '0;
    hilo_wr  = 1'b0;

    if (accept) begin
      op_d    = in_op;
      cnt_d   = CW'(MUL_LAT - 1);
      mul_a_d = {in_signed & in_a[31], in_a};
      mul_b_d = {in_signed & in_b[31], in_b};
    end else if (state_q == S_MUL && cnt_q != '0) begin
      cnt_d = cnt_q - CW'(1);
    end

    // A flush kills any HI/LO or result update scheduled for this edge.
    if (!flush) begin
      if (state_q == S_CAP) begin
        case (op_q)
          3'd0, 3'd1: begin
            hilo_new = mul_p[63:0];
            hilo_wr  = 1'b1;
          end
          3'd2:    res_d  = mul_p[31:0];
          3'd7:    res_d  = '0;
          default: prod_d = mul_p[63:0];
        endcase
      end else if (state_q == S_ACC) begin
        hilo_new = op_sub ? ({hi_q, lo_q} - prod_q) : ({hi_q, lo_q} + prod_q);
        hilo_wr  = 1'b1;
      end
    end

    // The multiply write takes precedence over a coincident MTHI/MTLO.
    if (hilo_wr) begin
      hi_d  = hilo_new[63:32];
      lo_d  = hilo_new[31:0];
      res_d = hilo_new[31:0];
    end else begin
      if (hi_we) hi_d = hilo_wdata;
      if (lo_we) lo_d = hilo_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q    <= '0;
      cnt_q   <= '0;
      mul_a_q <= '0;
      mul_b_q <= '0;
      prod_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      res_q   <= '0;
    end else begin
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      mul_a_q <= mul_a_d;
      mul_b_q <= mul_b_d;
      prod_q  <= prod_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      res_q   <= res_d;
    end
  end

  assign mul_a      = mul_a_q;
  assign mul_b      = mul_b_q;
  assign hi         = hi_q;
  assign lo         = lo_q;
  assign out_result = res_q;

endmodule

// File: tb/tb_mul_hilo_ctrl.sv
// tb/tb_mul_hilo_ctrl.sv - scoreboard bench for mul_hilo_ctrl with a 2-stage multiplier model
module tb_mul_hilo_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_op;
  logic [31:0] in_a, in_b;
  logic        flush;
  logic [32:0] mul_a, mul_b;
  logic [65:0] mul_p;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        hi_we, lo_we;
  logic [31:0] hilo_wdata;
  logic [31:0] hi, lo;

  typedef struct packed {
    logic [31:0] res;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  mul_hilo_ctrl #(.MUL_LAT(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .flush(flush), .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .hi_we(hi_we), .lo_we(lo_we), .hilo_wdata(hilo_wdata), .hi(hi), .lo(lo)
  );

  // External 33x33 signed multiplier, two register stages.
  logic signed [65:0] p1, p2;
  always @(posedge clk) begin
    p1 <= $signed(mul_a) * $signed(mul_b);
    p2 <= p1;
  end
  assign mul_p = p2;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every output handshake.
  always @(negedge clk) begin
    #1;
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_output", 64'(out_result), 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("out_result", 64'(out_result), 64'(e.res));
        chk("hi", 64'(hi), 64'(e.hi));
        chk("lo", 64'(lo), 64'(e.lo));
      end
    end
  end

  task automatic mt_write(input logic whi, input logic wlo, input logic [31:0] d);
    @(negedge clk);
    hi_we = whi; lo_we = wlo; hilo_wdata = d;
    @(negedge clk);
    hi_we = 1'b0; lo_we = 1'b0;
  endtask

  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] er, input logic [31:0] eh, input logic [31:0] el,
                       input int lat, input logic push, input logic mt_cap);
    int n;
    @(negedge clk);
    chk("in_ready_idle", 64'(in_ready), 64'd1);
    if (push) exp_q.push_back('{res: er, hi: eh, lo: el});
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b;
    @(posedge clk);
    #1 in_valid = 1'b0;
    for (n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (mt_cap && n == 3) begin lo_we = 1'b1; hilo_wdata = 32'hDEAD_0000; end
      if (mt_cap && n == 4) lo_we = 1'b0;
      if (out_valid) break;
    end
    lo_we = 1'b0;
    chk("latency", 64'(n), 64'(lat));
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_op = '0; in_a = '0; in_b = '0; flush = 1'b0;
    out_ready = 1'b1; hi_we = 1'b0; lo_we = 1'b0; hilo_wdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_hilo", {hi, lo}, 64'd0);
    chk("rst_mul_ops", {mul_a[31:0], mul_b[31:0]}, 64'd0);
    chk("rst_result", 64'(out_result), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("in_ready_after_rst", 64'(in_ready), 64'd1);

    do_op(3'd0, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFF1, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 4, 1'b1, 1'b0);
    chk("mult_mul_a", 64'(mul_a), 64'h1_FFFF_FFFD);
    chk("mult_mul_b", 64'(mul_b), 64'h0_0000_0005);

    do_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFE, 32'h0000_0001, 4, 1'b1, 1'b0);
    chk("multu_mul_a", 64'(mul_a), 64'h0_FFFF_FFFF);
    chk("multu_mul_b", 64'(mul_b), 64'h0_FFFF_FFFF);

    mt_write(1'b1, 1'b0, 32'h0);
    mt_write(1'b0, 1'b1, 32'hFFFF_FFFF);
    chk("mt_hilo", {hi, lo}, 64'h0000_0000_FFFF_FFFF);
    do_op(3'd4, 32'd1, 32'd1, 32'h0, 32'h1, 32'h0, 5, 1'b1, 1'b0);
    do_op(3'd6, 32'd1, 32'd1, 32'hFFFF_FFFF, 32'h0, 32'hFFFF_FFFF, 5, 1'b1, 1'b0);

    mt_write(1'b1, 1'b0, 32'h1234_5678);
    mt_write(1'b0, 1'b1, 32'h9ABC_DEF0);
    do_op(3'd2, 32'd7, 32'd6, 32'd42, 32'h1234_5678, 32'h9ABC_DEF0, 4, 1'b1, 1'b0);

    // Flush in the CAP cycle: no HI/LO write, no output.
    @(negedge clk);
    in_valid = 1'b1; in_op = 3'd0; in_a = 32'd2; in_b = 32'd3;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (3) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_out_valid", 64'(out_valid), 64'd0);
    chk("flush_in_ready", 64'(in_ready), 64'd1);
    repeat (3) @(negedge clk);
    chk("flush_hilo", {hi, lo}, 64'h1234_5678_9ABC_DEF0);
    chk("flush_no_valid", 64'(out_valid), 64'd0);

    // Back-pressure: result held three cycles.
    out_ready = 1'b0;
    do_op(3'd0, 32'd2, 32'd3, 32'd6, 32'd0, 32'd6, 4, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      chk("hold_valid", 64'(out_valid), 64'd1);
      chk("hold_result", 64'(out_result), 64'd6);
      chk("hold_in_ready", 64'(in_ready), 64'd0);
      @(negedge clk);
    end
    chk("hold_valid_last", 64'(out_valid), 64'd1);
    out_ready = 1'b1;
    @(negedge clk);
    chk("post_hs_in_ready", 64'(in_ready), 64'd1);
    chk("post_hs_valid", 64'(out_valid), 64'd0);

    do_op(3'd5, 32'hFFFF_FFFF, 32'd2, 32'd8, 32'd0, 32'd8, 5, 1'b1, 1'b0);
    do_op(3'd3, 32'h8000_0000, 32'h8000_0000, 32'd8, 32'h4000_0000, 32'd8, 5, 1'b1, 1'b0);
    do_op(3'd7, 32'd9, 32'd9, 32'd0, 32'h4000_0000, 32'd8, 4, 1'b1, 1'b0);
    mt_write(1'b1, 1'b1, 32'hA5A5_A5A5);
    chk("mt_both", {hi, lo}, 64'hA5A5_A5A5_A5A5_A5A5);
    // MTLO coinciding with the MULT write edge loses.
    do_op(3'd0, 32'd2, 32'd3, 32'd6, 32'd0, 32'd6, 4, 1'b1, 1'b1);

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mul_hilo_ctrl.md
Name: mul_hilo_ctrl

Overview:
- EXE-stage controller that sits directly upstream of the 2-stage 33x33 signed pipelined multiplier.
- Accepts one MIPS multiply-class op at a time and builds the 33-bit sign- or zero-extended operands for the multiplier.
- Tracks the multiplier's fixed latency and consumes its 66-bit product.
- Performs MADD/MSUB accumulation, owns the architectural HI/LO registers, and returns a result to the pipeline over a valid/ready handshake.

Parameters:
- MUL_LAT, 2, fixed pipeline latency of the external multiplier in cycles (operand edge to valid product).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  op request
- in_ready  out  1  controller can accept an op
- in_op  in  3  0 MULT, 1 MULTU, 2 MUL, 3 MADD, 4 MADDU, 5 MSUB, 6 MSUBU; 7 reserved
- in_a  in  32  rs operand
- in_b  in  32  rt operand
- flush  in  1  kill the in-flight op (exception/branch flush)
- mul_a  out  33  multiplier operand A
- mul_b  out  33  multiplier operand B
- mul_p  in  66  multiplier product
- out_valid  out  1  result available
- out_ready  in  1  downstream accepts result
- out_result  out  32  MUL: product[31:0]; other ops: new LO
- hi_we  in  1  MTHI write enable
- lo_we  in  1  MTLO write enable
- hilo_wdata  in  32  MTHI/MTLO data
- hi  out  32  current HI
- lo  out  32  current LO

Behaviour:
- Reset (sync, rst=1): state IDLE; hi, lo, mul_a, mul_b, out_result = 0; out_valid = 0; in_ready = 0 during reset, 1 in the first cycle after.
- States: IDLE, MUL (countdown), CAP, ACC, DONE.
- in_ready = (state==IDLE). Accept when in_valid & in_ready.
- On accept:
  - Register operands: signed ops (0,2,3,5) use {x[31],x}; unsigned ops (1,4,6) use {1'b0,x}.
  - Latch op; load countdown with MUL_LAT-1; go to MUL.
  - in_op=7 is accepted and completes as a NOP: no HI/LO write, out_result = 0.
- mul_a/mul_b hold their value from the accept edge until the next accept.
- MUL: decrement the counter each cycle; go to CAP when it reaches 0. mul_p is valid in CAP.
- CAP:
  - prod = mul_p[63:0].
  - MULT/MULTU: {hi,lo} <= prod; go to DONE.
  - MUL: out_result <= prod[31:0]; HI/LO unchanged; go to DONE.
  - MADD/MSUB family: register prod; go to ACC.
- ACC: {hi,lo} <= {hi,lo} +/- prod, modulo 2^64 (no overflow trap); go to DONE.
- out_result <= new LO at the same edge as the HI/LO write.
- Latency from the accept cycle T: out_valid first high in cycle T+MUL_LAT+2 (mult/mul) or T+MUL_LAT+3 (madd/msub). Default is T+4 / T+5.
- DONE:
  - out_valid = 1; out_result is stable while out_valid & !out_ready.
  - Go to IDLE on out_ready.
  - No back-to-back accept in DONE; in_ready is only high in IDLE.
- Flush:
  - Synchronous; priority below rst and above everything else.
  - From any state, go to IDLE next cycle, with out_valid low that cycle.
  - A HI/LO update scheduled at the same edge is suppressed.
  - Flush in DONE does not undo a HI/LO write already made.
- MTHI/MTLO:
  - Apply at any edge.
  - If one coincides with a multiply HI/LO update edge, the multiply update wins.
  - hi_we and lo_we may both be set; both registers then take hilo_wdata.
- HI/LO read ports are registered values. There is no bypass of the pending multiply result.

Test Plan:
- MULT a=0xFFFFFFFD (-3), b=5 -> cycle T+4 out_valid=1, hi=0xFFFFFFFF, lo=0xFFFFFFF1, out_result=0xFFFFFFF1.
- MULTU a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001, mul_a=mul_b=0x0FFFFFFFF.
- MTLO 0xFFFFFFFF, then MADDU a=1, b=1 -> out_valid at T+5, hi=1, lo=0. Then MSUBU a=1, b=1 -> hi=0, lo=0xFFFFFFFF.
- MUL a=7, b=6 with hi=0x12345678, lo=0x9ABCDEF0 preset -> out_result=42, hi/lo unchanged.
- MULT a=2, b=3 with flush pulsed in the CAP cycle -> hi/lo unchanged, out_valid never set, in_ready=1 in the next cycle.
- MULT a=2, b=3 with out_ready low for 3 cycles after out_valid -> out_valid and out_result=6 held; in_ready stays 0 until the out_ready handshake, then 1 in the following cycle.
